block_mem_responder: RTL and testbench

- Main-memory responder at the far end of the cache-to-memory block interface.
- Accepts one 128-bit block read or write request from the cache controller.
- Models a fixed access latency, then returns a one-cycle ready pulse; on reads, the block data is returned with it.
- Serves as the memory side for cache simulation and FPGA bring-up. It serves one request at a time.

---
 rtl/block_mem_responder_pkg.sv | 18 +
 rtl/block_mem_responder_if.sv | 22 ++
 rtl/block_mem_responder_ram_array.sv | 24 ++
 rtl/block_mem_responder.sv | 132 +++++++++++++
 tb/tb_block_mem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/block_mem_responder_pkg.sv
// Shared types and constants for the cache-to-memory block responder.
// The package keeps the short name mem_pkg because the cache side imports it too.
package mem_pkg;

    localparam int DEF_BLOCK_WIDTH  = 128;
    localparam int WORD_OFFSET_BITS = 2;
    localparam int LAT_CNT_WIDTH    = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/block_mem_responder_if.sv
// Block request/response bus between the cache controller (master) and main memory (slave).
interface block_mem_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = mem_pkg::DEF_BLOCK_WIDTH
);
    logic                   mem_req;
    logic                   mem_rw;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [BLOCK_WIDTH-1:0] mem_wdata;
    logic [BLOCK_WIDTH-1:0] mem_rdata;
    logic                   mem_ready;

    modport master (
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/block_mem_responder_ram_array.sv
// Block storage: 2**IDX_WIDTH blocks, synchronous write, combinational read.
module block_ram_array #(
    parameter int IDX_WIDTH   = 10,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [IDX_WIDTH-1:0]   idx,
    input  logic [BLOCK_WIDTH-1:0] wdata,
    output logic [BLOCK_WIDTH-1:0] rdata
);

    logic [BLOCK_WIDTH-1:0] mem [2**IDX_WIDTH];

    // NOTE: storage has no reset so it maps onto block RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/block_mem_responder.sv
// Main-memory responder: accepts one block read/write, waits LATENCY cycles, pulses mem_ready.
// One request in flight at a time; mem_req is only sampled in IDLE.
module block_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int IDX_WIDTH   = 10,
    parameter int LATENCY     = 4    // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,
    block_mem_if.slave  bus,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD = LAT_CNT_WIDTH'(LATENCY - 1);

    state_t                   state;
    state_t                   state_next;
    logic [LAT_CNT_WIDTH-1:0] lat_cnt;
    logic                     rw_q;
    logic [IDX_WIDTH-1:0]     idx_q;
    logic [BLOCK_WIDTH-1:0]   wdata_q;
    logic [BLOCK_WIDTH-1:0]   rdata_q;
    logic [BLOCK_WIDTH-1:0]   ram_rdata;
    logic [15:0]              rd_cnt_q;
    logic [15:0]              wr_cnt_q;
    logic                     ram_we;
    logic                     ready;
    logic                     accept;
    logic                     done;
    logic [IDX_WIDTH-1:0]     req_idx;
    logic                     unused_addr_bits;

    // High address bits alias onto the same block; word offset selects nothing here.
    assign req_idx          = bus.mem_addr[IDX_WIDTH+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
    assign unused_addr_bits = ^{bus.mem_addr[ADDR_WIDTH-1:IDX_WIDTH+WORD_OFFSET_BITS],
                                bus.mem_addr[WORD_OFFSET_BITS-1:0]};

    assign accept = (state == IDLE) && bus.mem_req;
    assign done   = (state == BUSY) && (lat_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.mem_req) state_next = BUSY;
            BUSY:    if (lat_cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // mem_ready is the RESP state itself, so rst drops it asynchronously with the state register.
    always_comb begin
        busy   = 1'b0;
        ready  = 1'b0;
        ram_we = 1'b0;
        unique case (state)
            IDLE: ;
            BUSY: begin
                busy   = 1'b1;
                ram_we = (lat_cnt == '0) && (rw_q == MEM_WRITE);
            end
            RESP: begin
                busy  = 1'b1;
                ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
            rw_q    <= MEM_READ;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            lat_cnt <= LAT_LOAD;
            rw_q    <= bus.mem_rw;
            idx_q   <= req_idx;
            wdata_q <= bus.mem_wdata;
        end else if ((state == BUSY) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (done) begin
            if (rw_q == MEM_READ) begin
                rdata_q  <= ram_rdata;
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end else begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    block_ram_array #(
        .IDX_WIDTH  (IDX_WIDTH),
        .BLOCK_WIDTH(BLOCK_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign bus.mem_ready = ready;
    assign bus.mem_rdata = rdata_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_block_mem_responder;
    import mem_pkg::*;

    localparam logic [127:0] D1 = 128'h44443333_22221111_DEADBEEF_CAFEF00D;
    localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
    localparam logic [127:0] DP = 128'hAAAA5555_AAAA5555_11112222_33334444;
    localparam logic [127:0] DQ = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    localparam logic [127:0] D3 = 128'hFEEDFACE_00000001_00000002_00000003;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy4, busy1;
    logic [15:0] rd4, wr4, rd1, wr1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    block_mem_if #(.ADDR_WIDTH(32), .BLOCK_WIDTH(128)) bus4 ();
    block_mem_if #(.ADDR_WIDTH(32), .BLOCK_WIDTH(128)) bus1 ();

    block_mem_responder #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .rd_count(rd4), .wr_count(wr4)
    );

    block_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .rd_count(rd1), .wr_count(wr1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on the LATENCY=4 instance; lat = edges from acceptance to ready.
    task automatic txn4(input logic rw, input logic [31:0] addr, input logic [127:0] wdata,
                        output logic [127:0] rdata, output int lat);
        bit seen = 0;
        int cyc  = 0;
        lat   = -1;
        rdata = '0;
        @(negedge clk);
        bus4.mem_req = 1'b1; bus4.mem_rw = rw; bus4.mem_addr = addr; bus4.mem_wdata = wdata;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 0) check("busy_after_accept", busy4, 1);
            if (bus4.mem_ready) begin
                seen  = 1;
                lat   = cyc;
                rdata = bus4.mem_rdata;
                bus4.mem_req = 1'b0;
            end
            cyc++;
        end
        if (!seen) begin
            bus4.mem_req = 1'b0;
            check("ready_timeout4", 0, 1);
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_one_cycle4", bus4.mem_ready, 0);
    endtask

    task automatic txn1(input logic rw, input logic [31:0] addr, input logic [127:0] wdata,
                        output logic [127:0] rdata, output int lat);
        bit seen = 0;
        int cyc  = 0;
        lat   = -1;
        rdata = '0;
        @(negedge clk);
        bus1.mem_req = 1'b1; bus1.mem_rw = rw; bus1.mem_addr = addr; bus1.mem_wdata = wdata;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.mem_ready) begin
                seen  = 1;
                lat   = cyc;
                rdata = bus1.mem_rdata;
                bus1.mem_req = 1'b0;
            end
            cyc++;
        end
        if (!seen) begin
            bus1.mem_req = 1'b0;
            check("ready_timeout1", 0, 1);
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_one_cycle1", bus1.mem_ready, 0);
    endtask

    initial begin
        logic [127:0] rd;
        logic [127:0] data_a, data_b;
        logic [12:0]  rdy_seen;
        int           lat;

        rst = 1'b1;
        bus4.mem_req = 0; bus4.mem_rw = 0; bus4.mem_addr = '0; bus4.mem_wdata = '0;
        bus1.mem_req = 0; bus1.mem_rw = 0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",  bus4.mem_ready, 0);
        check("rst_rdata",  bus4.mem_rdata, 0);
        check("rst_busy",   busy4, 0);
        check("rst_rd_cnt", rd4, 0);
        check("rst_wr_cnt", wr4, 0);
        rst = 1'b0;

        // Write then read index 16.
        txn4(MEM_WRITE, 32'h0000_0040, D1, rd, lat);
        check("wr_latency", lat, 4);
        check("wr_count_1", wr4, 1);
        check("busy_idle",  busy4, 0);
        txn4(MEM_READ, 32'h0000_0040, '0, rd, lat);
        check("rd_latency", lat, 4);
        check("rd_data",    rd, D1);
        check("rd_count_1", rd4, 1);
        check("rdata_hold", bus4.mem_rdata, D1);

        // Index 5 written via 0x14, read back through aliased address 0x1017.
        txn4(MEM_WRITE, 32'h0000_0014, D2, rd, lat);
        txn4(MEM_READ,  32'h0000_1017, '0, rd, lat);
        check("alias_data", rd, D2);
        check("alias_rd_cnt", rd4, 2);
        check("alias_wr_cnt", wr4, 2);

        // Back-to-back reads with mem_req held; inputs disturbed while the first is BUSY.
        rdy_seen = '0;
        data_a = '0;
        data_b = '0;
        @(negedge clk);
        bus4.mem_req = 1'b1; bus4.mem_rw = MEM_READ; bus4.mem_addr = 32'h40; bus4.mem_wdata = '0;
        for (int k = 0; k < 13; k++) begin
            @(posedge clk);
            @(negedge clk);
            rdy_seen[k] = bus4.mem_ready;
            if (k == 4)  data_a = bus4.mem_rdata;
            if (k == 10) data_b = bus4.mem_rdata;
            if (k == 0) begin
                bus4.mem_addr = 32'h14; bus4.mem_rw = MEM_WRITE; bus4.mem_wdata = DQ;
            end
            if (k == 2)  bus4.mem_rw = MEM_READ;
            if (k == 10) bus4.mem_req = 1'b0;
        end
        check("b2b_ready_pattern", rdy_seen, 13'b0_0100_0001_0000);
        check("b2b_data_first",  data_a, D1);
        check("b2b_data_second", data_b, D2);
        check("b2b_rd_cnt", rd4, 4);
        check("b2b_wr_cnt", wr4, 2);

        // Reset two cycles into a write of index 7; prior contents must survive.
        txn4(MEM_WRITE, 32'h0000_001C, DP, rd, lat);
        @(negedge clk);
        bus4.mem_req = 1'b1; bus4.mem_rw = MEM_WRITE; bus4.mem_addr = 32'h1C; bus4.mem_wdata = DQ;
        @(posedge clk);
        @(negedge clk);
        bus4.mem_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy4, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy",   busy4, 0);
        check("midrst_ready",  bus4.mem_ready, 0);
        check("midrst_rd_cnt", rd4, 0);
        check("midrst_wr_cnt", wr4, 0);
        @(negedge clk);
        rst = 1'b0;
        txn4(MEM_READ, 32'h0000_001C, '0, rd, lat);
        check("midrst_prior_data", rd, DP);
        check("post_rst_rd_cnt", rd4, 1);
        check("post_rst_wr_cnt", wr4, 0);

        // LATENCY = 1 instance, then counter wrap from a preloaded count.
        txn1(MEM_WRITE, 32'h0000_0000, D3, rd, lat);
        check("l1_wr_latency", lat, 1);
        txn1(MEM_READ, 32'h0000_0000, '0, rd, lat);
        check("l1_rd_latency", lat, 1);
        check("l1_rd_data", rd, D3);
        check("l1_rd_cnt", rd1, 1);
        @(negedge clk);
        force dut1.rd_cnt_q = 16'hFFFE;
        #1;
        release dut1.rd_cnt_q;
        txn1(MEM_READ, 32'h0000_0000, '0, rd, lat);
        check("wrap_ffff", rd1, 16'hFFFF);
        txn1(MEM_READ, 32'h0000_0000, '0, rd, lat);
        check("wrap_zero", rd1, 16'h0000);
        check("wrap_wr_cnt", wr1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
